// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 RGB444 capture write stage.
package ov7670_pkg;

    localparam int PIX_W        = 12;
    localparam int H_ACTIVE_DEF = 320;
    localparam int V_ACTIVE_DEF = 240;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS_HIGH,
        WAIT_VS_LOW,
        CAPTURE
    } cap_state_e;

endpackage

// File: rtl/rgb444_byte_pair.sv
// Pairs OV7670 RGB444 bytes into 12-bit pixels: byte 0 carries R in its low nibble,
// byte 1 carries {G,B}. The phase restarts at 0 on every HREF rising edge.
module rgb444_byte_pair
    import ov7670_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             href,
    input  logic             href_prev,
    input  logic [7:0]       data,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data
);

    logic       phase_q, phase_d;
    logic [3:0] red_q, red_d;
    logic       phase_eff;

    always_comb begin
        phase_eff = (href && !href_prev) ? 1'b0 : phase_q;
        phase_d   = phase_q;
        red_d     = red_q;
        pix_valid = 1'b0;
        if (clear) begin
            phase_d = 1'b0;
            red_d   = 4'h0;
        end else if (en && href) begin
            phase_d   = ~phase_eff;
            pix_valid = phase_eff;
            if (!phase_eff) red_d = data[3:0];
        end
        pix_data = {red_q, data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 1'b0;
            red_q   <= 4'h0;
        end else begin
            phase_q <= phase_d;
            red_q   <= red_d;
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture write stage: arms on i_Capture_En, writes one frame row-major into the frame buffer.
// Optional OV7670_CAPTURE_ERR_EN adds the sticky o_Line_Err geometry check.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Capture_En,
    input  logic              i_VSync,
    input  logic              i_HRef,
    input  logic [7:0]        i_Data,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic              o_Wr_DV,
    output logic [PIX_W-1:0]  o_Wr_Data,
    output logic              o_Frame_Done,
    output logic              o_Busy,
    output logic              o_Line_Err
);

    // Counters run one past the stored geometry so overlong lines/frames stay detectable.
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam int ROW_W = $clog2(V_ACTIVE + 2);
    localparam logic [COL_W-1:0]  COL_LIM  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACTIVE + 1);
    localparam logic [ROW_W-1:0]  ROW_LIM  = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(V_ACTIVE + 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(H_ACTIVE);

    cap_state_e        state_q, state_d;
    logic              vsync_q, href_q, vsync_prev_q, href_prev_q;
    logic [7:0]        data_q;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_dv_q, wr_dv_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;

    logic             vs_rise, vs_fall, href_fall, in_capture, start_frame;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;

    assign vs_rise     = vsync_q & ~vsync_prev_q;
    assign vs_fall     = ~vsync_q & vsync_prev_q;
    assign href_fall   = ~href_q & href_prev_q;
    assign in_capture  = (state_q == CAPTURE);
    assign start_frame = (state_q == WAIT_VS_LOW) && vs_fall;

    rgb444_byte_pair u_pair (
        .clk       (i_Clk),
        .rst       (i_Rst),
        .clear     (start_frame),
        .en        (in_capture),
        .href      (href_q),
        .href_prev (href_prev_q),
        .data      (data_q),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE:         if (i_Capture_En) state_d = WAIT_VS_HIGH;
            WAIT_VS_HIGH: if (vsync_q) state_d = WAIT_VS_LOW;
            WAIT_VS_LOW:  if (vs_fall) state_d = CAPTURE;
            CAPTURE: begin
                if (vs_rise) begin
                    frame_done_d = 1'b1;
                    state_d      = i_Capture_En ? WAIT_VS_LOW : IDLE;
                end
            end
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        base_d    = base_q;
        wr_dv_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (start_frame) begin
            row_d  = '0;
            col_d  = '0;
            base_d = '0;
        end else if (in_capture) begin
            if (pix_valid) begin
                if (col_q < COL_LIM && row_q < ROW_LIM) begin
                    wr_dv_d   = 1'b1;
                    wr_addr_d = base_q + ADDR_W'(col_q);
                    wr_data_d = pix_data;
                end
                if (col_q != COL_MAX) col_d = col_q + 1'b1;
            end else if (href_fall && col_q != '0) begin
                col_d = '0;
                if (row_q != ROW_MAX) row_d = row_q + 1'b1;
                // Base stops at the last stored row so it never wraps past the buffer.
                if (row_q < ROW_LAST) base_d = base_q + STRIDE;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            base_q       <= '0;
            wr_dv_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= i_VSync;
            href_q       <= i_HRef;
            data_q       <= i_Data;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
            row_q        <= row_d;
            col_q        <= col_d;
            base_q       <= base_d;
            wr_dv_q      <= wr_dv_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef OV7670_CAPTURE_ERR_EN
    logic line_err_q, line_err_d;

    always_comb begin
        line_err_d = line_err_q;
        if (start_frame) begin
            line_err_d = 1'b0;
        end else if (in_capture) begin
            if (href_fall && col_q != COL_LIM) line_err_d = 1'b1;
            if (vs_rise && row_q != ROW_LIM)   line_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) line_err_q <= 1'b0;
        else       line_err_q <= line_err_d;
    end

    assign o_Line_Err = line_err_q;
`else
    assign o_Line_Err = 1'b0;
`endif

    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_DV      = wr_dv_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Busy       = in_capture;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 16x8 geometry; writes are scoreboarded
// as {addr,data} words against a byte-level model built while stimulus is driven.
module tb_ov7670_capture;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = $clog2(H * V);
    localparam int W  = AW + 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_en;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic [AW-1:0] wr_addr;
    logic          wr_dv;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          busy;
    logic          line_err;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic err_at_done = 1'b0;
    int m_row = 0;
    bit m_err = 1'b0;

    ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Capture_En (cap_en),
        .i_VSync      (vsync),
        .i_HRef       (href),
        .i_Data       (data),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_DV      (wr_dv),
        .o_Wr_Data    (wr_data),
        .o_Frame_Done (frame_done),
        .o_Busy       (busy),
        .o_Line_Err   (line_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_dv) got_q.push_back({wr_addr, wr_data});
        if (frame_done) begin
            done_cnt    = done_cnt + 1;
            err_at_done = line_err;
        end
    end

    task automatic vsync_fall();
        m_row = 0;
        m_err = 1'b0;
        vsync = 1'b1;
        repeat (6) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic vsync_rise();
        if (m_row != V) m_err = 1'b1;
        vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // pat=1 sends (0x0F,0xF0) pairs, otherwise random bytes; cap says whether writes are expected.
    task automatic drive_line(input int nbytes, input bit cap, input bit pat);
        logic [7:0] b0;
        logic [7:0] b;
        int npix;
        npix = 0;
        b0 = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            b = pat ? ((i % 2 == 0) ? 8'h0F : 8'hF0) : 8'($urandom_range(0, 255));
            href = 1'b1;
            data = b;
            if (i % 2 == 0) begin
                b0 = b;
            end else begin
                if (cap && npix < H && m_row < V)
                    exp_q.push_back({AW'(m_row * H + npix), b0[3:0], b});
                npix++;
            end
        end
        @(negedge clk);
        href = 1'b0;
        data = 8'h00;
        repeat (4) @(negedge clk);
        if (npix != H) m_err = 1'b1;
        if (npix > 0) m_row++;
    endtask

    function automatic bit exp_err_val();
`ifdef OV7670_CAPTURE_ERR_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; cap_en = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_dv, wr_addr, wr_data, frame_done, busy, line_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got dv=%0b addr=%0d data=%h done=%0b busy=%0b err=%0b, need all 0",
                     wr_dv, wr_addr, wr_data, frame_done, busy, line_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_frame();
        logic [W-1:0] e, g;
        bit ee;
        done_cnt = 0;
        cap_en = 1'b1;
        vsync_fall();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %0b need 1", busy); end
        for (int r = 0; r < V; r++) drive_line(2 * H, 1'b1, 1'b1);
        vsync_rise();
        ee = exp_err_val();
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL full_done: got %0d need 1", done_cnt); end
        n_cmp++;
        if (err_at_done !== ee) begin n_err++; $display("FAIL full_err: got %0b need %0b", err_at_done, ee); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL full_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL full_write: got %h need %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_overflow();
        logic [W-1:0] e, g;
        bit ee;
        done_cnt = 0;
        vsync_fall();
        drive_line(2 * H + 2, 1'b1, 1'b0);
        for (int r = 1; r < V + 1; r++) drive_line(2 * H, 1'b1, 1'b0);
        vsync_rise();
        ee = exp_err_val();
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL ovf_done: got %0d need 1", done_cnt); end
        n_cmp++;
        if (err_at_done !== ee) begin n_err++; $display("FAIL ovf_err: got %0b need %0b", err_at_done, ee); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovf_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL ovf_write: got %h need %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_short_line();
        logic [W-1:0] e, g;
        bit ee;
        done_cnt = 0;
        vsync_fall();
        drive_line(2 * H, 1'b1, 1'b0);
        drive_line(10, 1'b1, 1'b0);
        for (int r = 2; r < V; r++) drive_line(2 * H, 1'b1, 1'b0);
        vsync_rise();
        ee = exp_err_val();
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL short_done: got %0d need 1", done_cnt); end
        n_cmp++;
        if (err_at_done !== ee) begin n_err++; $display("FAIL short_err: got %0b need %0b", err_at_done, ee); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL short_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL short_write: got %h need %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_odd_line();
        logic [W-1:0] e, g;
        bit ee;
        done_cnt = 0;
        vsync_fall();
        drive_line(7, 1'b1, 1'b0);
        for (int r = 1; r < V; r++) drive_line(2 * H, 1'b1, 1'b0);
        vsync_rise();
        ee = exp_err_val();
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL odd_done: got %0d need 1", done_cnt); end
        n_cmp++;
        if (err_at_done !== ee) begin n_err++; $display("FAIL odd_err: got %0b need %0b", err_at_done, ee); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL odd_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL odd_write: got %h need %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_cap_en_drop();
        logic [W-1:0] e, g;
        done_cnt = 0;
        vsync_fall();
        for (int r = 0; r < V; r++) begin
            if (r == 2) cap_en = 1'b0;
            drive_line(2 * H, 1'b1, 1'b0);
        end
        vsync_rise();
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL drop_done: got %0d need 1", done_cnt); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %0b need 0", busy); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL drop_count: got %0d need %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL drop_write: got %h need %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
        done_cnt = 0;
        vsync_fall();
        for (int r = 0; r < 3; r++) drive_line(2 * H, 1'b0, 1'b0);
        vsync_rise();
        n_cmp++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL unarmed_writes: got %0d need 0", got_q.size()); end
        n_cmp++;
        if (done_cnt !== 0) begin n_err++; $display("FAIL unarmed_done: got %0d need 0", done_cnt); end
        got_q.delete();
    endtask

    task automatic test_reset_mid_capture();
        cap_en = 1'b1;
        vsync_fall();
        drive_line(2 * H, 1'b1, 1'b0);
        @(negedge clk);
        href = 1'b1; data = 8'h5A;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({wr_dv, wr_addr, wr_data, frame_done, busy, line_err} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: got dv=%0b addr=%0d data=%h done=%0b busy=%0b err=%0b, need all 0",
                     wr_dv, wr_addr, wr_data, frame_done, busy, line_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        href = 1'b0;
        exp_q.delete(); got_q.delete(); done_cnt = 0;
        for (int r = 0; r < 3; r++) drive_line(2 * H, 1'b0, 1'b0);
        vsync_rise();
        n_cmp++;
        if (got_q.size() !== 0) begin n_err++; $display("FAIL midrst_writes: got %0d need 0", got_q.size()); end
        n_cmp++;
        if (done_cnt !== 0) begin n_err++; $display("FAIL midrst_done: got %0d need 0", done_cnt); end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overflow();
        test_short_line();
        test_odd_line();
        test_cap_en_drop();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
